poly_uniform_stream: RTL and testbench
======================================

// Module: poly_uniform_stream
// PURPOSE
//  Streaming, parametrised successor of the fixed 5-block uniform sampler used for Dilithium
//  matrix expansion. Drives the SHAKE128 init/squeeze engines and rejection-samples squeezed
//  bytes into N coefficients in [0,Q). Coefficients leave on a valid/ready stream.
//  Unlike the fixed sampler, it squeezes extra blocks one at a time until N coefficients are
//  accepted. Sits between the XOF core and the ExpandA coefficient store / NTT input.
// PARAMETERS
//  N           256      coefficients per polynomial
//  Q           8380417  modulus; candidate accepted iff cand < Q
//  COEFF_W     32       coefficient output width (zero-extended 23-bit candidate)
//  IN_W        64       XOF stream beat width; multiple of 8; (BLOCK_BYTES*8)%IN_W==0
//  BLOCK_BYTES 168      SHAKE128 rate in bytes; multiple of 3
//  INIT_BLOCKS 5        blocks requested on the first squeeze
// PORTS
//  clock        in   1        rising-edge clock
//  reset_n      in   1        asynchronous, active-low reset
//  start        in   1        level; sampled only in IDLE
//  seed         in   256      rho; captured at start
//  nonce        in   16       (i<<8)|j; captured at start
//  xof_init     out  1        1-cycle pulse: absorb xof_seed/xof_nonce
//  xof_seed     out  256      registered copy of seed
//  xof_nonce    out  16       registered copy of nonce
//  xof_init_done in  1        1-cycle pulse from absorb engine
//  xof_sqz      out  1        1-cycle pulse: squeeze xof_nblocks blocks
//  xof_nblocks  out  8        INIT_BLOCKS on first squeeze, 1 on each refill
//  xof_data     in   IN_W     squeezed bytes, byte 0 in bits [7:0]
//  xof_valid    in   1        xof_data valid
//  xof_ready    out  1        beat accepted when xof_valid & xof_ready
//  coef_data    out  COEFF_W  accepted coefficient
//  coef_idx     out  8        coefficient index 0..N-1
//  coef_valid   out  1        coefficient valid; held until coef_ready
//  coef_ready   in   1        downstream accept
//  busy         out  1        high in every state except IDLE
//  done         out  1        high in DONE
//  rej_count    out  16       rejected candidates (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0 except xof_seed/xof_nonce (also 0). All counters 0.
//  FSM: IDLE -start-> INIT (xof_init pulse on entry) -xof_init_done-> SQZ (xof_sqz pulse,
//   req_bytes+=nblocks*BLOCK_BYTES) -> SAMPLE.
//  In SAMPLE: ctr==N -> DRAIN. byte_cnt==req_bytes with ctr<N -> SQZ, nblocks=1.
//  DRAIN: xof_ready=1; beats are discarded until byte_cnt==req_bytes -> DONE.
//  DONE: done=1 while start high; start low -> IDLE. Back-to-back runs need start deasserted
//   for >=1 cycle.
//  Beat buffer: xof_ready=1 only in SAMPLE/DRAIN with the buffer empty. An accepted beat is
//   consumed one byte per cycle, LSB first, so one beat takes IN_W/8 cycles.
//  Byte stall: consumption stalls while coef_valid & ~coef_ready.
//  Triplet: bytes b0,b1,b2 form cand = {b2[6:0],b1,b0}; b2[7] is ignored. 3-byte phase
//   counter wraps 2->0. No triplet spans a block because BLOCK_BYTES%3==0.
//  Accept: on the b2 cycle, if cand<Q, register coef_valid=1, coef_data=cand, coef_idx=ctr;
//   ctr++ on the handshake. Otherwise discard; rej_count++ when enabled.
//  Latency: b2 consumed -> coef_valid next cycle.
//  Counters: ctr saturates at N. Once ctr==N, bytes remaining in the current request are
//   drained, never sampled.
//  Ignored inputs: start outside IDLE; xof_init_done outside INIT; xof_valid when ready=0.
//  Reset mid-operation returns to IDLE and drops any pending coefficient. The XOF engines
//   are reset by the same reset_n.
// CONFIGURATION
//  POLY_UNIFORM_REJ_STATS_EN defined:
//   - rej_count counts rejected candidates for the current run.
//   - Cleared on the IDLE->INIT transition; saturates at 16'hFFFF.
//  Not defined:
//   - rej_count tied to 0; no counter logic synthesised.
//   - All other behaviour identical.
// TESTING
//  1 Known vector: seed=0, nonce=0; XOF model from C ref -> 256 coefs match ref poly_uniform;
//    exactly one xof_sqz, nblocks=5; done=1; drain consumes 840 bytes total.
//  2 Boundaries: triplets 00 E0 7F (Q-1) accepted as 8380416; 01 E0 7F (Q) rejected;
//    01 00 80 -> 1 (bit 7 masked); FF FF FF rejected.
//  3 Refill: first 840 bytes all FF -> zero coefs, then xof_sqz with nblocks=1.
//    Feed valid bytes -> 56 coefs per block; repeat until 256; rej_count=280 with
//    POLY_UNIFORM_REJ_STATS_EN.
//  4 Backpressure: coef_ready random 30% -> no coef lost/duplicated; coef_data stable while
//    stalled; coef_idx runs 0..255 contiguously.
//  5 Reset mid-run: reset_n low after coefficient 100 -> all outputs 0 at once; new start
//    runs cleanly from coef_idx 0.
//  6 Handshake: start held during DONE keeps done=1; start pulsed in SAMPLE is ignored;
//    xof_valid toggling randomly gives the same result as test 1.

Source files
------------

// File: rtl/poly_uniform_stream_if.sv
// Signal bundle between poly_uniform_stream, the SHAKE128 absorb/squeeze engines and the
// coefficient sink. The sampler is the master; the environment is the slave.
interface poly_uniform_stream_if #(
  parameter int IN_W    = 64,
  parameter int COEFF_W = 32
);
  // Run control
  logic               start;
  logic [255:0]       seed;
  logic [15:0]        nonce;
  logic               busy;
  logic               done;
  logic [15:0]        rej_count;

  // XOF engine side
  logic               xof_init;
  logic [255:0]       xof_seed;
  logic [15:0]        xof_nonce;
  logic               xof_init_done;
  logic               xof_sqz;
  logic [7:0]         xof_nblocks;
  logic [IN_W-1:0]    xof_data;
  logic               xof_valid;
  logic               xof_ready;

  // Coefficient stream
  logic [COEFF_W-1:0] coef_data;
  logic [7:0]         coef_idx;
  logic               coef_valid;
  logic               coef_ready;

  modport master (
    input  start, seed, nonce, xof_init_done, xof_data, xof_valid, coef_ready,
    output busy, done, rej_count, xof_init, xof_seed, xof_nonce, xof_sqz, xof_nblocks,
           xof_ready, coef_data, coef_idx, coef_valid
  );

  modport slave (
    output start, seed, nonce, xof_init_done, xof_data, xof_valid, coef_ready,
    input  busy, done, rej_count, xof_init, xof_seed, xof_nonce, xof_sqz, xof_nblocks,
           xof_ready, coef_data, coef_idx, coef_valid
  );
endinterface

// File: rtl/poly_uniform_stream.sv
// Streaming rejection sampler: squeezes SHAKE128 blocks until N coefficients in [0,Q) are out.
// Optional feature: define POLY_UNIFORM_REJ_STATS_EN to count rejected candidates on rej_count.
module poly_uniform_stream #(
  parameter int N           = 256,
  parameter int Q           = 8380417,
  parameter int COEFF_W     = 32,
  parameter int IN_W        = 64,
  parameter int BLOCK_BYTES = 168,
  parameter int INIT_BLOCKS = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  poly_uniform_stream_if.master bus
);

  localparam int BEAT_BYTES = IN_W / 8;
  localparam int CTR_W      = $clog2(N + 2);
  localparam int BCNT_W     = $clog2(BEAT_BYTES + 1);
  localparam int CNT_W      = 32;
  localparam logic [23:0] Q_V = 24'(Q);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SQZ,
    S_SAMPLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [255:0]       seed_q;
  logic [15:0]        nonce_q;
  logic               init_pulse;
  logic               sqz_pulse;
  logic [7:0]         nblocks_q;

  logic [CTR_W-1:0]   ctr;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   req_bytes;
  logic [IN_W-1:0]    beat;
  logic [BCNT_W-1:0]  beat_left;
  logic [1:0]         phase;
  logic [7:0]         b0, b1;

  logic               coef_valid_q;
  logic [COEFF_W-1:0] coef_data_q;
  logic [7:0]         coef_idx_q;

  logic               start_run;
  logic               buf_empty;
  logic               req_exhausted;
  logic               hs;
  logic               stall;
  logic               full;
  logic               ready;
  logic               consume;
  logic               sample_b2;
  logic [22:0]        cand;
  logic               accept;
  logic [CTR_W-1:0]   idx_next;

  assign start_run     = (state == S_IDLE) && bus.start;
  assign buf_empty     = (beat_left == '0);
  assign req_exhausted = (byte_cnt == req_bytes);
  assign hs            = coef_valid_q && bus.coef_ready;
  assign stall         = coef_valid_q && !bus.coef_ready;

  // A coefficient still waiting for its handshake already occupies the last slot, so sampling
  // must stop one early or a 257th coefficient could be produced in the handshake cycle.
  assign full = (ctr == CTR_W'(N)) || (coef_valid_q && (ctr == CTR_W'(N - 1)));

  // Beats are refused once the outstanding request is fully buffered.
  assign ready = ((state == S_SAMPLE) || (state == S_DRAIN)) && buf_empty && !req_exhausted;

  assign consume = !buf_empty &&
                   (((state == S_SAMPLE) && !full && !stall) || (state == S_DRAIN));

  assign sample_b2 = consume && (state == S_SAMPLE) && (phase == 2'd2);
  assign cand      = {beat[6:0], b1, b0};
  assign accept    = sample_b2 && ({1'b0, cand} < Q_V);
  assign idx_next  = ctr + CTR_W'(hs);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_next = S_INIT;
      S_INIT:   if (bus.xof_init_done) state_next = S_SQZ;
      S_SQZ:    state_next = S_SAMPLE;
      S_SAMPLE: begin
        if (ctr == CTR_W'(N))                  state_next = S_DRAIN;
        else if (req_exhausted && !coef_valid_q) state_next = S_SQZ;
      end
      S_DRAIN:  if (req_exhausted) state_next = S_DONE;
      S_DONE:   if (!bus.start) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seed_q       <= '0;
      nonce_q      <= '0;
      init_pulse   <= 1'b0;
      sqz_pulse    <= 1'b0;
      nblocks_q    <= '0;
      ctr          <= '0;
      byte_cnt     <= '0;
      req_bytes    <= '0;
      beat         <= '0;
      beat_left    <= '0;
      phase        <= '0;
      b0           <= '0;
      b1           <= '0;
      coef_valid_q <= 1'b0;
      coef_data_q  <= '0;
      coef_idx_q   <= '0;
    end else begin
      init_pulse <= start_run;
      sqz_pulse  <= (state_next == S_SQZ);

      if (start_run) begin
        seed_q    <= bus.seed;
        nonce_q   <= bus.nonce;
        ctr       <= '0;
        byte_cnt  <= '0;
        req_bytes <= '0;
        beat_left <= '0;
        phase     <= '0;
      end

      if (state_next == S_SQZ) begin
        nblocks_q <= (state == S_INIT) ? 8'(INIT_BLOCKS) : 8'd1;
      end

      if (state == S_SQZ) begin
        req_bytes <= req_bytes + CNT_W'(nblocks_q) * CNT_W'(BLOCK_BYTES);
      end

      // Beat buffer: load when empty, then shift out one byte per consumed cycle.
      if (ready && bus.xof_valid) begin
        beat      <= bus.xof_data;
        beat_left <= BCNT_W'(BEAT_BYTES);
      end else if (consume) begin
        beat      <= beat >> 8;
        beat_left <= beat_left - BCNT_W'(1);
      end

      if (consume) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end

      if (consume && (state == S_SAMPLE)) begin
        if (phase == 2'd0) b0 <= beat[7:0];
        if (phase == 2'd1) b1 <= beat[7:0];
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end

      if (accept) begin
        coef_valid_q <= 1'b1;
        coef_data_q  <= COEFF_W'(cand);
        coef_idx_q   <= 8'(idx_next);
      end else if (hs) begin
        coef_valid_q <= 1'b0;
      end

      if (hs) begin
        ctr <= idx_next;
      end
    end
  end

`ifdef POLY_UNIFORM_REJ_STATS_EN
  logic        reject;
  logic [15:0] rej_q;

  assign reject = sample_b2 && !accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rej_q <= '0;
    end else if (start_run) begin
      rej_q <= '0;
    end else if (reject && (rej_q != 16'hFFFF)) begin
      rej_q <= rej_q + 16'd1;
    end
  end

  assign bus.rej_count = rej_q;
`else
  assign bus.rej_count = '0;
`endif

  assign bus.xof_init    = init_pulse;
  assign bus.xof_seed    = seed_q;
  assign bus.xof_nonce   = nonce_q;
  assign bus.xof_sqz     = sqz_pulse;
  assign bus.xof_nblocks = nblocks_q;
  assign bus.xof_ready   = ready;
  assign bus.coef_valid  = coef_valid_q;
  assign bus.coef_data   = coef_data_q;
  assign bus.coef_idx    = coef_idx_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);

endmodule

// File: tb/tb_poly_uniform_stream.sv
// Scoreboard bench for poly_uniform_stream: a byte-queue XOF model feeds directed streams,
// a monitor pops expected coefficients on every coefficient handshake.
`timescale 1ns/1ps
module tb_poly_uniform_stream;

  localparam int IN_W    = 64;
  localparam int COEFF_W = 32;
  localparam int BLOCK   = 168;
  localparam int BUDGET  = 20000;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  idx;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  poly_uniform_stream_if #(.IN_W(IN_W), .COEFF_W(COEFF_W)) bus ();

  poly_uniform_stream #(
    .N(256), .Q(8380417), .COEFF_W(COEFF_W), .IN_W(IN_W),
    .BLOCK_BYTES(BLOCK), .INIT_BLOCKS(5)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] stream[$];
  exp_t       exp_q[$];
  int         rd_ptr, granted, sqz_count, first_nb, refill_ones, beats, hs_count;
  bit         rand_valid, backpressure;

`ifdef POLY_UNIFORM_REJ_STATS_EN
  localparam bit REJ_EN = 1'b1;
`else
  localparam bit REJ_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // XOF model: squeezes grant bytes from the prepared stream, absorb completes 2 cycles later.
  initial begin
    bit fire;
    int init_wait;
    fire = 0;
    init_wait = 0;
    bus.xof_valid = 1'b0;
    bus.xof_data = '0;
    bus.xof_init_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        fire = 0;
        init_wait = 0;
        bus.xof_valid = 1'b0;
        bus.xof_init_done = 1'b0;
        continue;
      end
      if (fire) begin
        rd_ptr += 8;
        beats++;
      end
      bus.xof_init_done = 1'b0;
      if (init_wait > 0) begin
        init_wait--;
        if (init_wait == 0) bus.xof_init_done = 1'b1;
      end
      if (bus.xof_init) init_wait = 2;
      if (bus.xof_sqz) begin
        sqz_count++;
        granted += int'(bus.xof_nblocks) * BLOCK;
        if (sqz_count == 1) first_nb = int'(bus.xof_nblocks);
        else if (bus.xof_nblocks == 8'd1) refill_ones++;
      end
      if ((rd_ptr + 8 <= granted) && (rd_ptr + 8 <= stream.size()) &&
          (!rand_valid || ($urandom_range(0, 1) == 1))) begin
        bus.xof_valid = 1'b1;
        for (int i = 0; i < 8; i++) bus.xof_data[8*i +: 8] = stream[rd_ptr + i];
      end else begin
        bus.xof_valid = 1'b0;
      end
      fire = bus.xof_valid && bus.xof_ready;
    end
  end

  // Coefficient monitor: drives coef_ready, checks hold-while-stalled and pops the scoreboard.
  initial begin
    bit          stalled;
    logic [31:0] prev_data;
    logic [7:0]  prev_idx;
    exp_t        e;
    stalled = 0;
    prev_data = '0;
    prev_idx = '0;
    bus.coef_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        stalled = 0;
        bus.coef_ready = 1'b0;
        continue;
      end
      bus.coef_ready = backpressure ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if (bus.coef_valid) begin
        if (stalled) begin
          check("stall_data", bus.coef_data, prev_data);
          check("stall_idx", bus.coef_idx, prev_idx);
        end
        if (bus.coef_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_coef", bus.coef_idx, 256'h1_0000);
          end else begin
            e = exp_q.pop_front();
            check("coef_data", bus.coef_data, e.data);
            check("coef_idx", bus.coef_idx, e.idx);
          end
          hs_count++;
        end
        stalled = !bus.coef_ready;
        prev_data = bus.coef_data;
        prev_idx = bus.coef_idx;
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic prep();
    stream.delete();
    exp_q.delete();
    rd_ptr = 0;
    granted = 0;
    sqz_count = 0;
    first_nb = 0;
    refill_ones = 0;
    beats = 0;
    hs_count = 0;
  endtask

  task automatic push_trip(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    stream.push_back(x0);
    stream.push_back(x1);
    stream.push_back(x2);
  endtask

  task automatic push_val(input int v);
    logic [23:0] w;
    w = 24'(v);
    push_trip(w[7:0], w[15:8], w[23:16]);
  endtask

  task automatic push_exp(input int data, input int idx);
    exp_t e;
    e.data = 32'(data);
    e.idx = 8'(idx);
    exp_q.push_back(e);
  endtask

  // Five blocks: boundary triplets first, then 276 in-range values 1000+t.
  task automatic build_a();
    push_trip(8'h00, 8'hE0, 8'h7F);  // Q-1 accepted
    push_trip(8'h01, 8'hE0, 8'h7F);  // Q rejected
    push_trip(8'h01, 8'h00, 8'h80);  // bit 7 of b2 masked -> 1
    push_trip(8'hFF, 8'hFF, 8'hFF);  // 0x7FFFFF rejected
    for (int t = 0; t < 276; t++) push_val(1000 + t);
    push_exp(8380416, 0);
    push_exp(1, 1);
    for (int i = 2; i < 256; i++) push_exp(1000 + i - 2, i);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!bus.done && c < BUDGET) begin
      @(negedge clock);
      c++;
    end
    check({name, "_done"}, bus.done, 1);
  endtask

  initial begin
    logic [255:0] seed_v;
    int c;

    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.seed = '0;
    bus.nonce = '0;
    rand_valid = 0;
    backpressure = 0;
    prep();
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_coef_valid", bus.coef_valid, 0);
    check("rst_xof_ready", bus.xof_ready, 0);
    check("rst_nblocks", bus.xof_nblocks, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Known stream with boundary triplets; start held through DONE.
    build_a();
    bus.start = 1'b1;
    wait_done("t1");
    check("t1_sqz_count", sqz_count, 1);
    check("t1_first_nblocks", first_nb, 5);
    check("t1_bytes", beats * 8, 840);
    check("t1_left", exp_q.size(), 0);
    check("t1_coefs", hs_count, 256);
    check("t1_rej", bus.rej_count, REJ_EN ? 2 : 0);
    repeat (3) @(negedge clock);
    check("t1_done_held", bus.done, 1);
    check("t1_busy_held", bus.busy, 1);
    bus.start = 1'b0;
    @(negedge clock);
    check("t1_done_clear", bus.done, 0);
    check("t1_idle", bus.busy, 0);

    // Refill under backpressure: 840 rejected bytes, then 56 accepted values per block.
    prep();
    seed_v = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h8877665544332211};
    bus.seed = seed_v;
    bus.nonce = 16'h0102;
    for (int i = 0; i < 840; i++) stream.push_back(8'hFF);
    for (int k = 0; k < 280; k++) push_val(2000 + k);
    for (int k = 0; k < 256; k++) push_exp(2000 + k, k);
    backpressure = 1;
    bus.start = 1'b1;
    wait_done("t3");
    check("t3_seed", bus.xof_seed, seed_v);
    check("t3_nonce", bus.xof_nonce, 16'h0102);
    check("t3_sqz_count", sqz_count, 6);
    check("t3_first_nblocks", first_nb, 5);
    check("t3_refills_of_1", refill_ones, 5);
    check("t3_bytes", beats * 8, 1680);
    check("t3_left", exp_q.size(), 0);
    check("t3_rej", bus.rej_count, REJ_EN ? 280 : 0);
    bus.start = 1'b0;
    @(negedge clock);

    // Reset after coefficient 100 has been accepted.
    prep();
    build_a();
    bus.start = 1'b1;
    c = 0;
    while (hs_count < 101 && c < BUDGET) begin
      @(negedge clock);
      c++;
    end
    check("t5_reached_100", hs_count >= 101, 1);
    reset_n = 1'b0;
    bus.start = 1'b0;
    #1;
    check("t5_busy", bus.busy, 0);
    check("t5_done", bus.done, 0);
    check("t5_coef_valid", bus.coef_valid, 0);
    check("t5_coef_data", bus.coef_data, 0);
    check("t5_coef_idx", bus.coef_idx, 0);
    check("t5_xof_ready", bus.xof_ready, 0);
    check("t5_xof_sqz", bus.xof_sqz, 0);
    check("t5_xof_seed", bus.xof_seed, 0);
    check("t5_xof_nonce", bus.xof_nonce, 0);
    check("t5_rej", bus.rej_count, 0);
    repeat (2) @(negedge clock);
    prep();
    reset_n = 1'b1;
    @(negedge clock);

    // Clean rerun with random xof_valid gaps and a stray start pulse mid-sampling.
    build_a();
    backpressure = 0;
    rand_valid = 1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    c = 0;
    while (hs_count < 10 && c < BUDGET) begin
      @(negedge clock);
      c++;
    end
    check("t6_sampling", bus.busy, 1);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done("t6");
    check("t6_sqz_count", sqz_count, 1);
    check("t6_bytes", beats * 8, 840);
    check("t6_left", exp_q.size(), 0);
    check("t6_coefs", hs_count, 256);
    @(negedge clock);
    check("t6_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
